// File: rtl/fft_twiddle_sequencer_if.sv
// Twiddle output stream: one word per handshake, tagged with stage and index.
interface fft_twiddle_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tw_data;
    logic [ADDR_W-3:0] tw_stage;
    logic [1:0]        tw_k;
    logic              tw_last;
    logic              tw_valid;
    logic              tw_ready;

    modport master (
        output tw_data,
        output tw_stage,
        output tw_k,
        output tw_last,
        output tw_valid,
        input  tw_ready
    );

    modport slave (
        input  tw_data,
        input  tw_stage,
        input  tw_k,
        input  tw_last,
        input  tw_valid,
        output tw_ready
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Walks a registered twiddle ROM stage by stage and streams each word, tagged
// with stage/index, through a small credit-managed output FIFO.
module fft_twiddle_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              num_stages,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    fft_twiddle_sequencer_if.master tw
);
    localparam int STG_W      = ADDR_W - 2;
    localparam int S_W        = STG_W + 1;
    localparam int MAX_STAGES = 1 << STG_W;
    localparam int TAG_W      = STG_W + 3;
    localparam int ENT_W      = DATA_W + TAG_W;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [S_W-1:0]    stages_q, stages_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              done_q, done_d;

    logic              p0_valid_q, p0_valid_d;
    logic              p1_valid_q, p1_valid_d;
    logic [TAG_W-1:0]  p0_tag_q, p0_tag_d;
    logic [TAG_W-1:0]  p1_tag_q, p1_tag_d;

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [S_W-1:0]    stages_clamped;
    logic [ADDR_W-1:0] last_addr;
    logic [1:0]        inflight;
    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic [ENT_W-1:0]  head;
    logic              head_last;
    logic [TAG_W-1:0]  issue_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign stages_clamped = (int'(num_stages) > MAX_STAGES) ? S_W'(MAX_STAGES) : S_W'(num_stages);
    assign last_addr      = {STG_W'(stages_q - S_W'(1)), 2'b11};

    // Credit counts reads still in the ROM pipeline so the FIFO can never overflow.
    assign inflight   = {1'b0, p0_valid_q} + {1'b0, p1_valid_q};
    assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight);
    assign credit_ok  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

    assign fifo_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign head_last  = head[0];
    assign pop        = fifo_valid & tw.tw_ready;
    assign push       = p1_valid_q;

    always_comb begin
        state_d     = state_q;
        stages_d    = stages_q;
        next_addr_d = next_addr_q;
        rom_addr_d  = rom_addr_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_stages != 4'd0) begin
                        stages_d = stages_clamped;
                        issue    = 1'b1;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (next_addr_q == last_addr) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The tagged last word leaving the FIFO is the true end of frame.
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            rom_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(1);
        end
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            rom_addr_d  = '0;
            next_addr_d = '0;
        end
    end

    // Address zero issued from IDLE can never be the last word of a non-empty frame.
    always_comb begin
        issue_tag  = {next_addr_q, (state_q != IDLE) && (next_addr_q == last_addr)};
        p0_valid_d = issue;
        p0_tag_d   = issue ? issue_tag : p0_tag_q;
        p1_valid_d = p0_valid_q;
        p1_tag_d   = p0_tag_q;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {rom_data, p1_tag_q};
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stages_q    <= '0;
            next_addr_q <= '0;
            rom_addr_q  <= '0;
            done_q      <= 1'b0;
            p0_valid_q  <= 1'b0;
            p1_valid_q  <= 1'b0;
            p0_tag_q    <= '0;
            p1_tag_q    <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            stages_q    <= stages_d;
            next_addr_q <= next_addr_d;
            rom_addr_q  <= rom_addr_d;
            done_q      <= done_d;
            p0_valid_q  <= p0_valid_d;
            p1_valid_q  <= p1_valid_d;
            p0_tag_q    <= p0_tag_d;
            p1_tag_q    <= p1_tag_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Outputs read as zero whenever nothing valid is at the FIFO head.
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign rom_addr    = rom_addr_q;
    assign tw.tw_valid = fifo_valid;
    assign tw.tw_data  = fifo_valid ? head[ENT_W-1:TAG_W] : '0;
    assign tw.tw_stage = fifo_valid ? head[TAG_W-1:3] : '0;
    assign tw.tw_k     = fifo_valid ? head[2:1] : '0;
    assign tw.tw_last  = fifo_valid & head_last;
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: expected words are queued at start
// and compared at every stream handshake against a registered ROM model.
module tb_fft_twiddle_sequencer;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-3:0] stage;
        logic [1:0]        k;
        logic              last;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        num_stages;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    fft_twiddle_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) tw_if ();

    fft_twiddle_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_stages (num_stages),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tw         (tw_if)
    );

    always #5 clk = ~clk;

    // Registered ROM: data = addr * 0x11, valid one cycle after the address.
    always @(posedge clk) begin
        rom_data <= {11'b0, rom_addr} * 16'h0011;
    end

    word_t exp_q[$];
    int    checks     = 0;
    int    errors     = 0;
    int    frame_acc  = 0;
    int    frame_max  = 0;
    int    done_count = 0;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int s);
        int sc;
        word_t w;
        sc = (s > 8) ? 8 : s;
        for (int a = 0; a < 4 * sc; a++) begin
            w.data  = 16'(a * 17);
            w.stage = 3'(a >> 2);
            w.k     = 2'(a & 3);
            w.last  = (a == 4 * sc - 1);
            exp_q.push_back(w);
        end
        frame_acc  = 0;
        frame_max  = 0;
        num_stages = 4'(s);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit random_ready);
        int n;
        n = 0;
        while (!done && n < budget) begin
            if (random_ready) tw_if.tw_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        check_output(tag, 32'(done), 32'd1);
        tw_if.tw_ready = 1'b1;
    endtask

    // Scoreboard and occupancy monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (int'(rom_addr) > frame_max) frame_max = int'(rom_addr);
                check_output("outstanding_le_depth",
                             32'((int'(rom_addr) + 1 - frame_acc) <= FIFO_DEPTH), 32'd1);
            end
            if (tw_if.tw_valid && tw_if.tw_ready) begin
                check_output("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    word_t e;
                    e = exp_q.pop_front();
                    check_output("stream_word",
                                 32'({tw_if.tw_data, tw_if.tw_stage, tw_if.tw_k, tw_if.tw_last}),
                                 32'(e));
                end
                frame_acc++;
            end
            if (done) done_count++;
        end
    end

    initial begin
        int dc;
        rst            = 1'b1;
        start          = 1'b0;
        num_stages     = 4'd0;
        tw_if.tw_ready = 1'b0;
        tick(3);
        check_output("reset_ctrl", 32'({busy, done, rom_addr}), 32'd0);
        check_output("reset_stream",
                     32'({tw_if.tw_valid, tw_if.tw_last, tw_if.tw_k, tw_if.tw_stage, tw_if.tw_data}), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("[TB] S=2 streaming");
        tw_if.tw_ready = 1'b1;
        dc = done_count;
        apply_stimulus(2);
        check_output("t1_busy_addr_after_start", 32'({busy, rom_addr}), 32'h20);
        tick(1);
        check_output("t1_no_valid_e1", 32'(tw_if.tw_valid), 32'd0);
        tick(1);
        check_output("t1_valid_e2", 32'(tw_if.tw_valid), 32'd1);
        tick(7);
        check_output("t1_last_e9", 32'({tw_if.tw_valid, tw_if.tw_last}), 32'h3);
        check_output("t1_done_not_early", 32'(done), 32'd0);
        tick(1);
        check_output("t1_done_busy_valid_e10", 32'({done, busy, tw_if.tw_valid}), 32'h4);
        tick(1);
        check_output("t1_done_single", 32'(done), 32'd0);
        check_output("t1_word_count", 32'(frame_acc), 32'd8);
        check_output("t1_done_count", 32'(done_count - dc), 32'd1);
        check_output("t1_rom_addr_idle", 32'(rom_addr), 32'd0);

        $display("[TB] S=2 backpressure");
        tw_if.tw_ready = 1'b0;
        dc = done_count;
        apply_stimulus(2);
        tick(10);
        check_output("t2_rom_addr_stalled", 32'(rom_addr), 32'd3);
        check_output("t2_no_handshake", 32'(frame_acc), 32'd0);
        check_output("t2_head_held",
                     32'({tw_if.tw_valid, tw_if.tw_stage, tw_if.tw_k, tw_if.tw_data}), 32'h1_0000 << 5);
        tw_if.tw_ready = 1'b1;
        wait_done("t2_done", 40, 1'b0);
        tick(2);
        check_output("t2_word_count", 32'(frame_acc), 32'd8);
        check_output("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("t2_done_count", 32'(done_count - dc), 32'd1);

        $display("[TB] empty frame and ignored starts");
        dc = done_count;
        apply_stimulus(0);
        check_output("t3_empty_done", 32'({done, busy, tw_if.tw_valid}), 32'h4);
        tick(1);
        check_output("t3_empty_after", 32'({done, busy, tw_if.tw_valid}), 32'h0);
        check_output("t3_empty_done_count", 32'(done_count - dc), 32'd1);
        dc = done_count;
        apply_stimulus(3);
        tick(2);
        num_stages = 4'd2;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        tick(2);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        wait_done("t3_done", 60, 1'b0);
        tick(4);
        check_output("t3_word_count", 32'(frame_acc), 32'd12);
        check_output("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("t3_done_count", 32'(done_count - dc), 32'd1);
        check_output("t3_idle", 32'({busy, tw_if.tw_valid}), 32'd0);

        $display("[TB] reset mid-frame");
        apply_stimulus(4);
        begin
            int n;
            n = 0;
            while (frame_acc < 5 && n < 40) begin
                tick(1);
                n++;
            end
        end
        check_output("t4_reached_5", 32'(frame_acc), 32'd5);
        rst            = 1'b1;
        tw_if.tw_ready = 1'b0;
        tick(1);
        check_output("t4_reset_ctrl", 32'({busy, done, rom_addr}), 32'd0);
        check_output("t4_reset_stream",
                     32'({tw_if.tw_valid, tw_if.tw_last, tw_if.tw_k, tw_if.tw_stage, tw_if.tw_data}), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        tick(2);
        check_output("t4_no_stale_word", 32'(tw_if.tw_valid), 32'd0);
        tw_if.tw_ready = 1'b1;
        apply_stimulus(1);
        wait_done("t4_done", 30, 1'b0);
        tick(2);
        check_output("t4_word_count", 32'(frame_acc), 32'd4);
        check_output("t4_max_addr", 32'(frame_max), 32'd3);
        check_output("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] S=15 clamped, random ready");
        apply_stimulus(15);
        wait_done("t5_done", 600, 1'b1);
        tick(2);
        check_output("t5_word_count", 32'(frame_acc), 32'd32);
        check_output("t5_max_addr", 32'(frame_max), 32'd31);
        check_output("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
